// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop bits.
// Parity bit and parity_err are present only when SERIAL_FRAME_RX_PARITY_EN is defined.
module serial_frame_rx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic                 done,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic PARITY_SENSE = (PARITY_ODD != 0);

    localparam logic [2:0] ST_START  = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_PERR   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_bad_q, par_bad_d;
    logic                 err_seen_q, err_seen_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        par_bad_d  = par_bad_q;
        // Remembers that ERR was already occupied, so frame_err fires only once.
        err_seen_d = (state_q == ST_ERR);
        cnt_d      = cnt_q;

        case (state_q)
            ST_START: begin
                if (!in) begin
                    state_d   = ST_DATA;
                    idx_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            ST_DATA: begin
                shift_d[idx_q] = in;
                if (idx_q == LAST_DATA) begin
                    idx_d = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_PARITY: begin
                par_bad_d = (((^shift_q) ^ in) != PARITY_SENSE);
                state_d   = ST_STOP;
            end
            ST_STOP: begin
                if (!in) begin
                    state_d = ST_ERR;
                end else if (idx_q == LAST_STOP) begin
                    if (par_bad_q) begin
                        state_d = ST_PERR;
                    end else begin
                        state_d = ST_DONE;
                        data_d  = shift_q;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE, ST_PERR: begin
                // A start bit here begins the next frame with no idle cycle.
                if (!in) begin
                    state_d   = ST_DATA;
                    idx_d     = '0;
                    par_bad_d = 1'b0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_ERR: begin
                if (in) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase

        if ((frame_err || parity_err) && (cnt_q != {ERR_CNT_W{1'b1}})) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_START;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            par_bad_q  <= 1'b0;
            err_seen_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            par_bad_q  <= par_bad_d;
            err_seen_q <= err_seen_d;
            cnt_q      <= cnt_d;
        end
    end

    assign done      = (state_q == ST_DONE);
    assign frame_err = (state_q == ST_ERR) && !err_seen_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign parity_err = (state_q == ST_PERR);
`else
    assign parity_err = 1'b0;
`endif
    assign data      = data_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: default 8N1 instance, a 5-bit/2-stop/2-bit-counter instance,
// and an even-parity instance when SERIAL_FRAME_RX_PARITY_EN is defined.
module tb_serial_frame_rx;

    logic clk;
    logic rst;
    logic line_a, line_b, line_p;
    int   cyc;
    int   checks;
    int   errors;

    logic       done_a, ferr_a, perr_a;
    logic [7:0] data_a, cnt_a;
    logic       done_b, ferr_b, perr_b;
    logic [4:0] data_b;
    logic [1:0] cnt_b;

    int done_n_a, ferr_n_a, done_at_a;
    int done_n_b, ferr_n_b;

    serial_frame_rx dut_a (
        .clk(clk), .reset(rst), .in(line_a), .done(done_a), .data(data_a),
        .frame_err(ferr_a), .parity_err(perr_a), .err_count(cnt_a)
    );

    serial_frame_rx #(.DATA_BITS(5), .STOP_BITS(2), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .reset(rst), .in(line_b), .done(done_b), .data(data_b),
        .frame_err(ferr_b), .parity_err(perr_b), .err_count(cnt_b)
    );

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic       done_p, ferr_p, perr_p;
    logic [7:0] data_p, cnt_p;
    int         done_n_p;

    serial_frame_rx #(.PARITY_ODD(0)) dut_p (
        .clk(clk), .reset(rst), .in(line_p), .done(done_p), .data(data_p),
        .frame_err(ferr_p), .parity_err(perr_p), .err_count(cnt_p)
    );

    always @(negedge clk) if (done_p) done_n_p++;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a) begin done_n_a++; done_at_a = cyc; end
        if (ferr_a) ferr_n_a++;
        if (done_b) done_n_b++;
        if (ferr_b) ferr_n_b++;
    end

    // driver tasks: one bit per cycle on the selected line, others idle high
    task automatic tick(input int sel, input logic b);
        @(posedge clk);
        #1;
        line_a = 1'b1;
        line_b = 1'b1;
        line_p = 1'b1;
        case (sel)
            0: line_a = b;
            1: line_b = b;
            default: line_p = b;
        endcase
    endtask

    task automatic send_bits(input int sel, input logic [15:0] w, input int nbits,
                             input int par, input int nstop, input logic [1:0] stops);
        for (int i = 0; i < nbits; i++) tick(sel, w[i]);
        if (par >= 0) tick(sel, par[0]);
        for (int s = 0; s < nstop; s++) tick(sel, stops[s]);
    endtask

    task automatic send_frame(input int sel, input logic [15:0] w, input int nbits,
                              input int par, input int nstop, input logic [1:0] stops,
                              output int t);
        tick(sel, 1'b0);
        t = cyc;
        send_bits(sel, w, nbits, par, nstop, stops);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick(0, 1'b1);
        @(negedge clk);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", ferr_a); end
        checks++; if (perr_a !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", perr_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_a); end
        checks++; if (cnt_a !== 8'h00) begin errors++; $display("FAIL reset_err_count: got %h expected 00", cnt_a); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick(0, 1'b1);
        @(negedge clk);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL idle_done: got %b expected 0", done_a); end
    endtask

    task automatic test_frame_5a();
        int t;
        int n0, f0;
        n0 = done_n_a;
        f0 = ferr_n_a;
        send_frame(0, 16'h005A, 8, -1, 1, 2'b01, t);
        tick(0, 1'b1);
        @(negedge clk);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL f5a_done: got %b expected 1", done_a); end
        checks++; if (data_a !== 8'h5A) begin errors++; $display("FAIL f5a_data: got %h expected 5a", data_a); end
        repeat (3) tick(0, 1'b1);
        checks++; if (done_n_a - n0 != 1) begin errors++; $display("FAIL f5a_done_count: got %0d expected 1", done_n_a - n0); end
        checks++; if (done_at_a != t + 10) begin errors++; $display("FAIL f5a_done_cycle: got %0d expected %0d", done_at_a, t + 10); end
        checks++; if (ferr_n_a != f0) begin errors++; $display("FAIL f5a_frame_err: got %0d expected %0d", ferr_n_a, f0); end
        checks++; if (cnt_a !== 8'h00) begin errors++; $display("FAIL f5a_err_count: got %h expected 00", cnt_a); end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        int n0;
        n0 = done_n_a;
        send_frame(0, 16'h00FF, 8, -1, 1, 2'b01, t1);
        tick(0, 1'b0);
        t2 = cyc;
        @(negedge clk);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", done_a); end
        checks++; if (data_a !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", data_a); end
        send_bits(0, 16'h0000, 8, -1, 1, 2'b01);
        tick(0, 1'b1);
        @(negedge clk);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", done_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL b2b_data2: got %h expected 00", data_a); end
        repeat (2) tick(0, 1'b1);
        checks++; if (done_at_a != t1 + 20) begin errors++; $display("FAIL b2b_done2_cycle: got %0d expected %0d", done_at_a, t1 + 20); end
        checks++; if (done_n_a - n0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_n_a - n0); end
    endtask

    task automatic test_framing_error();
        int t;
        int n0, f0;
        n0 = done_n_a;
        f0 = ferr_n_a;
        send_frame(0, 16'h003C, 8, -1, 1, 2'b00, t);
        tick(0, 1'b0);
        @(negedge clk);
        checks++; if (ferr_a !== 1'b1) begin errors++; $display("FAIL ferr_pulse: got %b expected 1", ferr_a); end
        tick(0, 1'b0);
        @(negedge clk);
        checks++; if (ferr_a !== 1'b0) begin errors++; $display("FAIL ferr_second_cycle: got %b expected 0", ferr_a); end
        checks++; if (cnt_a !== 8'h01) begin errors++; $display("FAIL ferr_err_count: got %h expected 01", cnt_a); end
        repeat (3) tick(0, 1'b0);
        repeat (4) tick(0, 1'b1);
        checks++; if (ferr_n_a - f0 != 1) begin errors++; $display("FAIL ferr_pulse_count: got %0d expected 1", ferr_n_a - f0); end
        checks++; if (done_n_a != n0) begin errors++; $display("FAIL ferr_no_done: got %0d expected %0d", done_n_a, n0); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL ferr_data_held: got %h expected 00", data_a); end
        send_frame(0, 16'h0066, 8, -1, 1, 2'b01, t);
        tick(0, 1'b1);
        @(negedge clk);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL ferr_recover_done: got %b expected 1", done_a); end
        checks++; if (data_a !== 8'h66) begin errors++; $display("FAIL ferr_recover_data: got %h expected 66", data_a); end
    endtask

`ifdef SERIAL_FRAME_RX_PARITY_EN
    task automatic test_parity();
        int t;
        int n0;
        n0 = done_n_p;
        send_frame(2, 16'h0001, 8, 0, 1, 2'b01, t);
        tick(2, 1'b1);
        @(negedge clk);
        checks++; if (perr_p !== 1'b1) begin errors++; $display("FAIL par_bad_pulse: got %b expected 1", perr_p); end
        checks++; if (done_p !== 1'b0) begin errors++; $display("FAIL par_bad_no_done: got %b expected 0", done_p); end
        tick(2, 1'b1);
        @(negedge clk);
        checks++; if (cnt_p !== 8'h01) begin errors++; $display("FAIL par_err_count: got %h expected 01", cnt_p); end
        checks++; if (data_p !== 8'h00) begin errors++; $display("FAIL par_bad_data_held: got %h expected 00", data_p); end
        send_frame(2, 16'h0001, 8, 1, 1, 2'b01, t);
        tick(2, 1'b1);
        @(negedge clk);
        checks++; if (done_p !== 1'b1) begin errors++; $display("FAIL par_good_done: got %b expected 1", done_p); end
        checks++; if (perr_p !== 1'b0) begin errors++; $display("FAIL par_good_no_perr: got %b expected 0", perr_p); end
        checks++; if (data_p !== 8'h01) begin errors++; $display("FAIL par_good_data: got %h expected 01", data_p); end
        tick(2, 1'b1);
        checks++; if (done_n_p - n0 != 1) begin errors++; $display("FAIL par_done_count: got %0d expected 1", done_n_p - n0); end
    endtask
`endif

    task automatic test_saturation();
        logic [4:0] words [4];
        logic [1:0] exp_cnt [4];
        int t;
        int f0, n0;
        words   = '{5'h15, 5'h0A, 5'h1F, 5'h03};
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
        f0 = ferr_n_b;
        n0 = done_n_b;
        for (int k = 0; k < 4; k++) begin
            send_frame(1, {11'd0, words[k]}, 5, -1, 2, 2'b01, t);
            tick(1, 1'b1);
            @(negedge clk);
            checks++; if (ferr_b !== 1'b1) begin errors++; $display("FAIL sat_ferr_%0d: got %b expected 1", k, ferr_b); end
            tick(1, 1'b1);
            @(negedge clk);
            checks++; if (cnt_b !== exp_cnt[k]) begin errors++; $display("FAIL sat_count_%0d: got %0d expected %0d", k, cnt_b, exp_cnt[k]); end
        end
        tick(1, 1'b1);
        checks++; if (ferr_n_b - f0 != 4) begin errors++; $display("FAIL sat_pulse_count: got %0d expected 4", ferr_n_b - f0); end
        checks++; if (done_n_b != n0) begin errors++; $display("FAIL sat_no_done: got %0d expected %0d", done_n_b, n0); end
        checks++; if (data_b !== 5'h00) begin errors++; $display("FAIL sat_data_held: got %h expected 00", data_b); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        int t;
        int n0, f0;
        w = 8'hFF;
        tick(0, 1'b0);
        for (int i = 0; i < 4; i++) tick(0, w[i]);
        tick(0, w[4]);
        rst = 1'b1;
        tick(0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cnt_a !== 8'h00) begin errors++; $display("FAIL rmid_err_count: got %h expected 00", cnt_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", data_a); end
        n0 = done_n_a;
        f0 = ferr_n_a;
        repeat (12) tick(0, 1'b1);
        checks++; if (done_n_a != n0) begin errors++; $display("FAIL rmid_no_done: got %0d expected %0d", done_n_a, n0); end
        checks++; if (ferr_n_a != f0) begin errors++; $display("FAIL rmid_no_ferr: got %0d expected %0d", ferr_n_a, f0); end
        send_frame(0, 16'h00A5, 8, -1, 1, 2'b01, t);
        tick(0, 1'b1);
        @(negedge clk);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL rmid_done: got %b expected 1", done_a); end
        checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL rmid_data_a5: got %h expected a5", data_a); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        done_n_a  = 0;
        ferr_n_a  = 0;
        done_at_a = -1;
        done_n_b  = 0;
        ferr_n_b  = 0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        done_n_p  = 0;
`endif
        rst    = 1'b1;
        line_a = 1'b1;
        line_b = 1'b1;
        line_p = 1'b1;

        test_reset();
        test_frame_5a();
        test_back_to_back();
        test_framing_error();
`ifdef SERIAL_FRAME_RX_PARITY_EN
        test_parity();
`endif
        test_saturation();
        test_reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
